// File: rtl/serial_adder_nbits.sv
// Multi-cycle adder: S = A + B + cin computed CHUNK bits per clock, LSB chunk first,
// with start/ready/done handshake, held result and signed-overflow flag.
module serial_adder_nbits #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("serial_adder_nbits: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] s_d;
  logic             cout_d, ovf_d, done_d, busy_d, ready_d;

  // One CHUNK-wide ripple slice on the low bits of the shifting operand registers
  logic [CHUNK:0]   csum;
  logic             msb_cin;
  logic             last_chunk;

  always_comb begin
    csum       = (CHUNK+1)'(a_q[CHUNK-1:0]) + (CHUNK+1)'(b_q[CHUNK-1:0]) + (CHUNK+1)'(carry_q);
    msb_cin    = csum[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];
    last_chunk = (cnt_q == CW'(NCHUNK - 1));
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    s_d     = s;
    cout_d  = cout;
    ovf_d   = ovf;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Operands shift down so the next chunk is always at bit 0; sums shift in from the top
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        psum_d  = WIDTH'({csum[CHUNK-1:0], psum_q} >> CHUNK);
        carry_d = csum[CHUNK];
        cnt_d   = cnt_q + 1'b1;
        if (last_chunk) begin
          cnt_d   = '0;
          s_d     = psum_d;
          cout_d  = csum[CHUNK];
          ovf_d   = msb_cin ^ csum[CHUNK];
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d != RUN);
    busy_d  = (state_d == RUN);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      s       <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
      ready   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      s       <= s_d;
      cout    <= cout_d;
      ovf     <= ovf_d;
      done    <= done_d;
      busy    <= busy_d;
      ready   <= ready_d;
    end
  end

endmodule

// File: doc/serial_adder_nbits.md
Name: serial_adder_nbits

Overview:
- Parametrised multi-cycle adder, successor to the 4-bit combinational full adder.
- Computes S = A + B + cin over WIDTH/CHUNK clock cycles, using one CHUNK-bit ripple adder slice per cycle, LSB chunk first.
- Adds a start/ready/done handshake, result holding, and signed-overflow reporting.
- Used where a wide adder must be traded for area, and as a reusable arithmetic unit under sequential control.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be ≥ 1.
- CHUNK, 4, bits added per cycle; 1 ≤ CHUNK ≤ WIDTH; WIDTH % CHUNK must be 0, else elaboration error.
- NCHUNK, WIDTH/CHUNK, derived local parameter; not overridable.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted on a rising edge when start=1 and ready=1.
- a  in  WIDTH  operand A; sampled only on acceptance.
- b  in  WIDTH  operand B; sampled only on acceptance.
- cin  in  1  carry-in; sampled only on acceptance.
- ready  out  1  block can accept start.
- busy  out  1  computation in progress.
- done  out  1  one-cycle pulse when a new result is on s/cout/ovf.
- s  out  WIDTH  sum, registered, held between operations.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  two's-complement overflow: carry into MSB XOR cout.

Behaviour:
- Interface fixed: one clock; reset is asynchronous and active-low.
- FSM states: IDLE, RUN, DONE.
- Reset (rst_n=0, asserted asynchronously):
  - state=IDLE, chunk counter=0, carry register=0, internal operand/partial registers=0.
  - s=0, cout=0, ovf=0, done=0, busy=0, ready=1.
- ready=1 in IDLE and DONE; 0 in RUN. busy=1 only in RUN. done=1 only in DONE.
- IDLE:
  - start=1 at edge E0: capture a, b, cin into internal registers; counter=0; go to RUN.
  - start=0: stay in IDLE.
- RUN, one chunk per edge:
  - Edge Ek (k=1..NCHUNK) adds bits [(k-1)*CHUNK +: CHUNK] of the captured A and B plus the carry register.
  - The chunk sum goes to the internal partial-sum register; the chunk carry-out goes to the carry register; the counter increments.
  - On the final chunk, the carry into the MSB is also recorded for ovf.
  - On edge E_NCHUNK: write s=partial sum, cout=final carry, ovf=carry into MSB XOR final carry; go to DONE.
- Outputs s/cout/ovf change only on completion edges; they hold the previous result throughout RUN.
- Latency: done is high in the cycle after edge E_NCHUNK, i.e. NCHUNK cycles after acceptance.
  - Example: WIDTH=16, CHUNK=4 gives done in the 4th cycle after the accepting edge.
- DONE lasts exactly one cycle:
  - start=1: accept new operands (back-to-back) and go to RUN; done still drops after this cycle.
  - start=0: go to IDLE.
- start while busy=1 is ignored; a/b/cin changes during RUN have no effect.
- CHUNK=WIDTH: NCHUNK=1, single-cycle RUN; done one cycle after acceptance.
- WIDTH=1: ovf = cin_into_bit0 XOR cout.
- Wrap-around: sum modulo 2^WIDTH on s; carry on cout.
- rst_n asserted during RUN aborts the operation: no done, outputs go to reset values, and the partial result is discarded.
- No combinational path from inputs to outputs.

Test Plan:
- WIDTH=16, CHUNK=4: a=16'hFFFF, b=16'h0001, cin=0 -> busy for 4 cycles, done pulse; s=16'h0000, cout=1, ovf=0.
- WIDTH=16, CHUNK=4: a=16'h7FFF, b=16'h0001, cin=0 -> s=16'h8000, cout=0, ovf=1. Then a=16'h8000, b=16'h8000 -> s=0, cout=1, ovf=1.
- WIDTH=4, CHUNK=1, exhaustive sweep of all a, b (0..15) and cin (0,1), 512 cases -> each s/cout matches {cout,s}=a+b+cin; done exactly 4 cycles after each start; s unchanged while busy.
- Back-to-back: start held high continuously, a=3, b=5, then a=10, b=6 -> results 8 then 16 (mod 16 at WIDTH=4 -> s=0, cout=1). The second operation is accepted in the DONE cycle; done pulses once per operation.
- start pulsed and operands changed mid-RUN -> ignored; result reflects the originally captured operands; no extra done.
- rst_n dropped asynchronously mid-RUN (between edges) -> s=0, cout=0, ovf=0, ready=1 immediately; no done after release; next start computes correctly.
